// File: rtl/leds_pkg.sv
// Shared definitions for the Wishbone LED peripheral: register addresses,
// bus handshake states and register reset fill values.
package leds_pkg;

    // Register map seen on adr_i.
    typedef enum logic [1:0] {
        ADR_LED_DATA = 2'd0,
        ADR_BRIGHT   = 2'd1,
        ADR_WR_COUNT = 2'd2,
        ADR_UNMAPPED = 2'd3
    } leds_adr_e;

    // Responder handshake: idle, or presenting a one-cycle ack/err.
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_ERR  = 2'd2
    } bus_state_e;

    // Per-bit fill values, replicated to the register width at the use site.
    localparam logic LED_DATA_RST = 1'b0;
    localparam logic BRIGHT_RST   = 1'b1;

    // Accesses that get an error response when error reporting is built in:
    // anything to the unmapped slot, or a write to the read-only counter.
    function automatic logic is_err_access(input logic we, input leds_adr_e adr);
        return (adr == ADR_UNMAPPED) || (we && (adr == ADR_WR_COUNT));
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM stage for the LED peripheral: prescaler, free-running PWM counter,
// brightness shadow captured at period start, and registered per-bit gating.
module pwm_gen
    import leds_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PWM_PRESCALE = 4,
    parameter int PWM_BITS     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PWM_BITS-1:0]   bright,
    input  logic [DATA_WIDTH-1:0] led_data,
    output logic [DATA_WIDTH-1:0] led
);

    // One extra value keeps the width at least 1 bit when PWM_PRESCALE is 1.
    localparam int                 PRE_W    = $clog2(PWM_PRESCALE + 1);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PWM_PRESCALE - 1);
    // Counter stops one short of all-ones so BRIGHT=all-ones is always on.
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] shadow;
    logic                step;
    logic                pwm_on;

    assign step   = (pre == PRE_LAST);
    assign pwm_on = (cnt < shadow);

    // Prescaler: divides clk_i down to one PWM step per PWM_PRESCALE cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            pre <= '0;
        end else if (step) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // PWM counter; brightness is latched only at the wrap so a period in
    // progress keeps the pulse width it started with.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            shadow <= {PWM_BITS{BRIGHT_RST}};
        end else if (step) begin
            if (cnt == CNT_LAST) begin
                cnt    <= '0;
                shadow <= bright;
            end else begin
                cnt <= cnt + PWM_BITS'(1);
            end
        end
    end

    // Registered output gating keeps led glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led <= '0;
        end else begin
            led <= led_data & {DATA_WIDTH{pwm_on}};
        end
    end

endmodule

// File: rtl/wb_leds.sv
// Wishbone classic responder holding an LED pattern, a global brightness and
// a write counter, driving the LEDs through pwm_gen.
// Optional build macro: LEDS_ERR_EN -- unmapped accesses and writes to the
// read-only counter answer with err_o instead of ack_o.
module wb_leds
    import leds_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PWM_PRESCALE = 4,
    parameter int PWM_BITS     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [1:0]            adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] led_o
);

    bus_state_e            state;
    bus_state_e            state_nxt;
    leds_adr_e             adr;
    logic                  req;
    logic                  bad;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] led_data;
    logic [PWM_BITS-1:0]   bright;
    logic [DATA_WIDTH-1:0] wr_count;
    logic [DATA_WIDTH-1:0] rd_data;

    assign adr = leds_adr_e'(adr_i);
    // Idle state is exactly "ack_o=0 and err_o=0", so a new request can only
    // be sampled on the cycle after a response.
    assign req = cyc_i && stb_i && (state == BUS_IDLE);

`ifdef LEDS_ERR_EN
    assign bad = is_err_access(we_i, adr);
`else
    assign bad = 1'b0;
`endif

    assign wr_en = req && we_i && !bad;
    assign rd_en = req && !we_i && !bad;

    // Handshake state register; reset drops any pending response at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and response strobes: a response lasts exactly one cycle.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = BUS_IDLE;
        ack_o     = 1'b0;
        err_o     = 1'b0;
        if (req) begin
            state_nxt = bad ? BUS_ERR : BUS_ACK;
        end
        ack_o = (state == BUS_ACK);
`ifdef LEDS_ERR_EN
        err_o = (state == BUS_ERR);
`endif
    end

    // Register writes take effect on the sampling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_data <= {DATA_WIDTH{LED_DATA_RST}};
            bright   <= {PWM_BITS{BRIGHT_RST}};
            wr_count <= '0;
        end else if (wr_en) begin
            case (adr)
                ADR_LED_DATA: begin
                    led_data <= dat_i;
                    wr_count <= wr_count + DATA_WIDTH'(1);
                end
                ADR_BRIGHT: bright <= PWM_BITS'(dat_i);
                default:    ;
            endcase
        end
    end

    // Read mux; the unmapped slot reads as zero.
    always_comb begin
        rd_data = '0;
        case (adr)
            ADR_LED_DATA: rd_data = led_data;
            ADR_BRIGHT:   rd_data = DATA_WIDTH'(bright);
            ADR_WR_COUNT: rd_data = wr_count;
            default:      rd_data = '0;
        endcase
    end

    // Read data is captured on the sampling edge and cleared otherwise, so
    // dat_o is non-zero only during the ack cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_o <= '0;
        end else if (rd_en) begin
            dat_o <= rd_data;
        end else begin
            dat_o <= '0;
        end
    end

    pwm_gen #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PWM_PRESCALE (PWM_PRESCALE),
        .PWM_BITS     (PWM_BITS)
    ) u_pwm_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bright   (bright),
        .led_data (led_data),
        .led      (led_o)
    );

endmodule

// File: tb/tb_wb_leds.sv
// Directed self-checking bench for wb_leds (PWM_PRESCALE=1, 8-bit PWM).
// Honours LEDS_ERR_EN for the expected error responses.
module tb_wb_leds;

`ifdef LEDS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [1:0] adr_i = 2'd0;
    logic [7:0] dat_i = 8'd0;
    logic [7:0] dat_o;
    logic       ack_o;
    logic       err_o;
    logic [7:0] led_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    always #5 clk_i = ~clk_i;

    wb_leds #(
        .DATA_WIDTH   (8),
        .PWM_PRESCALE (1),
        .PWM_BITS     (8)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .err_o (err_o),
        .led_o (led_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer: response must come exactly one cycle after the sampling
    // edge, last one cycle, and leave dat_o at zero afterwards.
    task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output logic got_ack, output logic got_err);
        int lat;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wdata;
        lat = 0;
        do begin
            @(posedge clk_i); #1;
            lat++;
        end while (!(ack_o || err_o) && lat < 8);
        got_ack = ack_o;
        got_err = err_o;
        rdata   = dat_o;
        check("resp_latency", lat, 1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        check("resp_one_cycle", {ack_o, err_o}, 2'b00);
        check("dat_idle_zero", dat_o, 8'h00);
    endtask

    // Transfer with expected response kind and, for reads, expected data.
    task automatic xfer_expect(input string tag, input logic we, input logic [1:0] adr,
                               input logic [7:0] wdata, input logic exp_err, input logic [7:0] exp_rd);
        logic [7:0] rd;
        logic       a;
        logic       e;
        bus_xfer(we, adr, wdata, rd, a, e);
        check({tag, "_ack"}, a, !exp_err);
        check({tag, "_err"}, e, exp_err);
        if (!we) check({tag, "_rdata"}, rd, exp_rd);
    endtask

    task automatic write_led(input logic [7:0] v);
        xfer_expect("wr_led", 1'b1, 2'd0, v, 1'b0, 8'h00);
        exp_count = (exp_count + 1) % 256;
    endtask

    task automatic count_led(input int n, input logic [7:0] on_val,
                             output int on_cnt, output int off_cnt, output int other);
        on_cnt = 0; off_cnt = 0; other = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            if (led_o == on_val) on_cnt++;
            else if (led_o == 8'h00) off_cnt++;
            else other++;
        end
    endtask

    initial begin
        int         on_cnt;
        int         off_cnt;
        int         other;
        int         first_on;
        logic       found;
        logic [7:0] prev;

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ack", ack_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_dat", dat_o, 8'h00);
        check("rst_led", led_o, 8'h00);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // LED_DATA=0xA5 at full brightness: constantly on.
        write_led(8'hA5);
        count_led(300, 8'hA5, on_cnt, off_cnt, other);
        check("full_bright_on", on_cnt, 300);
        xfer_expect("rd_count1", 1'b0, 2'd2, 8'h00, 1'b0, 8'd1);
        xfer_expect("rd_led_a5", 1'b0, 2'd0, 8'h00, 1'b0, 8'hA5);
        xfer_expect("rd_bright_rst", 1'b0, 2'd1, 8'h00, 1'b0, 8'hFF);

        // BRIGHT=0x40: any full 255-cycle window has 64 on, 191 off.
        write_led(8'hFF);
        xfer_expect("wr_bright40", 1'b1, 2'd1, 8'h40, 1'b0, 8'h00);
        xfer_expect("rd_bright40", 1'b0, 2'd1, 8'h00, 1'b0, 8'h40);
        repeat (300) @(posedge clk_i);
        #1;
        count_led(255, 8'hFF, on_cnt, off_cnt, other);
        check("b40_on", on_cnt, 64);
        check("b40_off", off_cnt, 191);
        check("b40_other", other, 0);

        // BRIGHT=0x80, then BRIGHT=0x00 written just after a period starts.
        xfer_expect("wr_bright80", 1'b1, 2'd1, 8'h80, 1'b0, 8'h00);
        repeat (300) @(posedge clk_i);
        #1;
        found = 1'b0;
        prev  = led_o;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk_i); #1;
            if (prev == 8'h00 && led_o == 8'hFF) found = 1'b1;
            prev = led_o;
        end
        check("period_start_found", found, 1'b1);
        first_on = (led_o == 8'hFF) ? 1 : 0;
        fork
            xfer_expect("wr_bright00", 1'b1, 2'd1, 8'h00, 1'b0, 8'h00);
            count_led(254, 8'hFF, on_cnt, off_cnt, other);
        join
        check("midperiod_on", first_on + on_cnt, 128);
        count_led(255, 8'hFF, on_cnt, off_cnt, other);
        check("next_period_on", on_cnt, 0);
        check("next_period_off", off_cnt, 255);

        // WR_COUNT wraps from all-ones to zero.
        while (exp_count != 255) write_led(8'(exp_count));
        xfer_expect("rd_count255", 1'b0, 2'd2, 8'h00, 1'b0, 8'hFF);
        write_led(8'h3C);
        xfer_expect("rd_count_wrap", 1'b0, 2'd2, 8'h00, 1'b0, 8'(exp_count));
        check("model_wrapped", exp_count, 0);
        xfer_expect("rd_led_3c", 1'b0, 2'd0, 8'h00, 1'b0, 8'h3C);

        // Unmapped slot and read-only counter.
        xfer_expect("rd_adr3", 1'b0, 2'd3, 8'h00, ERR_EN, 8'h00);
        xfer_expect("wr_adr2", 1'b1, 2'd2, 8'h55, ERR_EN, 8'h00);
        xfer_expect("wr_adr3", 1'b1, 2'd3, 8'h77, ERR_EN, 8'h00);
        xfer_expect("rd_count_kept", 1'b0, 2'd2, 8'h00, 1'b0, 8'h00);
        xfer_expect("rd_led_kept", 1'b0, 2'd0, 8'h00, 1'b0, 8'h3C);

        // Reset asserted during the ack cycle.
        xfer_expect("wr_bright_ff", 1'b1, 2'd1, 8'hFF, 1'b0, 8'h00);
        write_led(8'h81);
        repeat (300) @(posedge clk_i);
        #1;
        check("led_before_rst", led_o, 8'h81);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 2'd0; dat_i = 8'h18;
        @(posedge clk_i); #1;
        check("ack_before_rst", ack_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("rst_ack_async", ack_o, 1'b0);
        check("rst_err_async", err_o, 1'b0);
        check("rst_led_async", led_o, 8'h00);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        xfer_expect("rd_bright_after_rst", 1'b0, 2'd1, 8'h00, 1'b0, 8'hFF);
        xfer_expect("rd_led_after_rst", 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        xfer_expect("rd_count_after_rst", 1'b0, 2'd2, 8'h00, 1'b0, 8'h00);
        check("led_after_rst", led_o, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_leds.md
Name: wb_leds

Overview:
- Wishbone classic responder (peripheral) driving board LEDs.
- Accepts the 8-bit writes issued by the button/switch controller, or by any other classic controller.
- Stores an LED on/off pattern and a global brightness value, then drives the LEDs through a glitch-free PWM stage.
- Sits on the shared Wishbone bus next to the debounced-input controller.

Parameters:
- DATA_WIDTH, 8, width of wb data and of the LED pattern register.
- PWM_PRESCALE, 4, clk_i cycles per PWM counter step (must be >= 1).
- PWM_BITS, 8, PWM counter/brightness width.

Ports:
- clk_i  input  1  system clock; the only clock in the block.
- rst_i  input  1  reset; asynchronous, active-high.
- cyc_i  input  1  Wishbone bus cycle valid.
- stb_i  input  1  Wishbone strobe.
- we_i  input  1  Wishbone write enable.
- adr_i  input  2  register address.
- dat_i  input  DATA_WIDTH  write data.
- dat_o  output  DATA_WIDTH  read data.
- ack_o  output  1  transfer acknowledge.
- err_o  output  1  error response; tied 0 unless LEDS_ERR_EN is defined.
- led_o  output  DATA_WIDTH  LED drive, active-high.

Behaviour:
- Reset values:
  - ack_o=0, err_o=0, dat_o=0, led_o=0.
  - LED_DATA=0, BRIGHT=all-ones, BRIGHT_SHADOW=all-ones, WR_COUNT=0.
  - PWM counter=0, prescaler=0.
- Register map:
  - 0 LED_DATA: RW.
  - 1 BRIGHT: RW, low PWM_BITS bits used.
  - 2 WR_COUNT: RO, counts LED_DATA writes, wraps at 2^DATA_WIDTH.
  - 3 unmapped.
- Handshake (classic, registered):
  - A request is cyc_i&stb_i high while ack_o=0 and err_o=0.
  - The request is sampled on that clock edge. ack_o is high for exactly the following cycle, then returns to 0 the cycle after, regardless of stb_i.
  - Write takes effect on the sampling edge. Read data is registered on the sampling edge and valid while ack_o=1.
  - dat_o returns to 0 when ack_o is low.
  - Back-to-back: the next request can be sampled at the earliest on the cycle after the ack cycle, giving 1 transfer per 2 cycles minimum.
  - cyc_i or stb_i dropping before ack: the request is still acked if already sampled; the controller ignores it.
- Unmapped address (no LEDS_ERR_EN): write ignored, read returns 0, ack_o asserted. Write to WR_COUNT: ignored, acked.
- PWM:
  - Prescaler counts 0..PWM_PRESCALE-1. The PWM counter steps once per prescaler wrap, over 0..2^PWM_BITS-2 (period 2^PWM_BITS-1 steps), then wraps to 0.
  - BRIGHT_SHADOW <= BRIGHT only when the PWM counter wraps to 0, so mid-period writes never shorten or lengthen the current pulse.
  - led_o[i] registered = LED_DATA[i] & (pwm_cnt < BRIGHT_SHADOW). Therefore BRIGHT=0 gives always off and BRIGHT=all-ones gives always on (no dropout cycle).
  - LED_DATA changes reach led_o 1 cycle after the write edge.
- Simultaneous events: a write to LED_DATA in the same cycle as WR_COUNT wrap from all-ones → WR_COUNT=0; no saturation.
- Reset mid-transaction: ack_o/err_o drop immediately (asynchronous) and the pending transfer is lost. Registers return to reset values.

Optional Feature:
- LEDS_ERR_EN defined:
  - Accesses to adr 3, and writes to adr 2, respond with err_o=1 for one cycle instead of ack_o. Same timing as ack_o.
  - No register is modified and dat_o=0.
- LEDS_ERR_EN undefined: err_o tied 0 and those accesses are acked as described above.

Decomposition:
- Package leds_pkg:
  - Address enum ADR_LED_DATA=0, ADR_BRIGHT=1, ADR_WR_COUNT=2.
  - Reset constants LED_DATA_RST, BRIGHT_RST.
- Sub-module pwm_gen, containing the prescaler, the PWM counter, shadow brightness capture, and the per-bit compare. Parameterised by PWM_PRESCALE and PWM_BITS.

Test Plan:
- Reset, then write LED_DATA=0xA5 with BRIGHT at reset value → ack_o high exactly 1 cycle after the sampling edge; led_o=0xA5 constantly; WR_COUNT reads 1.
- Write BRIGHT=0x40 with LED_DATA=0xFF, PWM_PRESCALE=1 → over one 255-cycle period after the next wrap, led_o=0xFF for 64 cycles and 0x00 for 191 cycles.
- Write BRIGHT=0x00 mid-period after BRIGHT=0x80 → current period still shows 128 on-cycles; the next period shows led_o=0 throughout.
- 256 writes to LED_DATA → WR_COUNT reads 0; the read returns on ack with dat_o valid only during the ack cycle.
- Read adr 3 and write adr 2 → without LEDS_ERR_EN: ack_o, read data 0, WR_COUNT unchanged. With LEDS_ERR_EN: err_o=1 for 1 cycle, ack_o=0.
- Assert rst_i in the cycle ack_o is high → ack_o=0 combinationally, led_o=0, BRIGHT reads all-ones after release.
